// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the data-memory arbiter.
// Struct field widths here follow the default memory geometry.
package dmem_arb_pkg;

  localparam int unsigned DmemAddrW       = 9;
  localparam int unsigned DmemDataW       = 32;
  localparam int unsigned DmemStarveLimit = 8;
  localparam int unsigned StarveCntW      = 8;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_AUX = 1'b1
  } port_id_e;

  typedef struct packed {
    logic                 we;
    logic [DmemAddrW-1:0] addr;
    logic [DmemDataW-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic     valid;
    port_id_e port;
  } rd_track_t;

  function automatic port_id_e onehot_to_port(input logic [1:0] grant);
    return (grant == 2'b10) ? PORT_AUX : PORT_CPU;
  endfunction

endpackage

// File: rtl/dmem_arb_picker.sv
// Combinational grant selection: a lone requester always wins; on a tie the
// preferred port (round-robin pointer or starvation flag) wins.
module dmem_arb_picker (
  input  logic [1:0] req_valid_i,
  input  logic       prefer_aux_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    unique case (req_valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = prefer_aux_i ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory (registered read).
// Define DMEM_ARB_RR_EN for round-robin; default is fixed priority with starvation promotion.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DmemAddrW,
  parameter int unsigned DATA_W       = DmemDataW,
  parameter int unsigned STARVE_LIMIT = DmemStarveLimit
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [1:0]          req_we_i,
  input  logic [2*ADDR_W-1:0] req_addr_i,
  input  logic [2*DATA_W-1:0] req_wdata_i,
  output logic [1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                mem_wr_o,
  output logic                mem_rd_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                arb_owner_o
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  logic [1:0] valid_act;
  logic       prefer_aux;
  logic [1:0] grant;
  logic       accept;
  port_id_e   grant_port;
  cmd_t       sel_cmd;

  // Nothing is accepted while reset is asserted, so all outputs stay quiet.
  assign valid_act = rst_i ? 2'b00 : req_valid_i;

  dmem_arb_picker u_picker (
    .req_valid_i  (valid_act),
    .prefer_aux_i (prefer_aux),
    .grant_o      (grant)
  );

  assign accept      = |grant;
  assign grant_port  = onehot_to_port(grant);
  assign req_ready_o = grant;
  assign arb_owner_o = grant[1];

`ifdef DMEM_ARB_RR_EN
  logic rr_aux_q, rr_aux_d;

  // Pointer names the port favoured on the next tie; moves only on a grant.
  always_comb begin
    rr_aux_d = rr_aux_q;
    if (accept) begin
      rr_aux_d = (grant_port == PORT_CPU);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_aux_q <= 1'b0;
    end else begin
      rr_aux_q <= rr_aux_d;
    end
  end

  assign prefer_aux = rr_aux_q;
`else
  localparam logic [StarveCntW-1:0] StarveMax = StarveCntW'(STARVE_LIMIT);

  logic [StarveCntW-1:0] starve_q, starve_d;

  // Counts cycles port 1 waits; saturates so promotion persists until served.
  always_comb begin
    starve_d = starve_q;
    if (!valid_act[1] || grant[1]) begin
      starve_d = '0;
    end else if (starve_q < StarveMax) begin
      starve_d = starve_q + StarveCntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign prefer_aux = (starve_q >= StarveMax);
`endif

  always_comb begin
    sel_cmd = '{we: req_we_i[0], addr: req_addr_i[ADDR_W-1:0], wdata: req_wdata_i[DATA_W-1:0]};
    if (grant_port == PORT_AUX) begin
      sel_cmd = '{we:    req_we_i[1],
                  addr:  req_addr_i[2*ADDR_W-1:ADDR_W],
                  wdata: req_wdata_i[2*DATA_W-1:DATA_W]};
    end
  end

  logic              mem_wr_q, mem_wr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  rd_track_t         trk0_q, trk0_d, trk1_q;

  always_comb begin
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    trk0_d      = '{valid: 1'b0, port: PORT_CPU};
    if (accept) begin
      mem_wr_d    = sel_cmd.we;
      mem_rd_d    = ~sel_cmd.we;
      mem_addr_d  = sel_cmd.addr;
      mem_wdata_d = sel_cmd.wdata;
      trk0_d      = '{valid: ~sel_cmd.we, port: grant_port};
    end
  end

  // trk0 lines up with mem_rd, trk1 with the returning mem_rdata.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      trk0_q      <= '{valid: 1'b0, port: PORT_CPU};
      trk1_q      <= '{valid: 1'b0, port: PORT_CPU};
    end else begin
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      trk0_q      <= trk0_d;
      trk1_q      <= trk0_q;
    end
  end

  assign mem_wr_o    = mem_wr_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  always_comb begin
    rsp_valid_o = 2'b00;
    rsp_rdata_o = '0;
    if (trk1_q.valid) begin
      rsp_valid_o = (trk1_q.port == PORT_AUX) ? 2'b10 : 2'b01;
      rsp_rdata_o = mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a cycle-level reference model;
// honours DMEM_ARB_RR_EN to select the arbitration rule being modelled.
module tb_dmem_arbiter;

  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int LIM = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0]      req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_wr, mem_rd;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            arb_owner;
  logic            mem_init = 1'b1;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .mem_wr_o    (mem_wr),
    .mem_rd_o    (mem_rd),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .arb_owner_o (arb_owner)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 10) return 32'h1;
    if (i == 11) return 32'h2;
    return DW'(i) * 32'h9E3779B1;
  endfunction

  // Single-port memory with registered read, driven by the DUT pins.
  logic [DW-1:0] mem [512];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
    end else begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
    end
  end

  // Reference model state.
  typedef struct {
    int            due;
    bit            port;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] ref_mem [512];
  rsp_t          rq[$];
  int            cyc = 0;
  int            starve = 0;
  bit            pref_aux = 1'b0;
  bit            exp_wr = 1'b0, exp_rd = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [1:0]    last_grant = '0;
  int            n_vec = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit r, input logic [1:0] v, input logic [1:0] we,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bit            g0, g1, p;
    logic [1:0]    exp_rv;
    logic [DW-1:0] exp_data;
    rsp_t          e;
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    @(negedge clk);
    cyc++;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!r) begin
      if (v == 2'b01) g0 = 1'b1;
      else if (v == 2'b10) g1 = 1'b1;
      else if (v == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
        if (pref_aux) g1 = 1'b1; else g0 = 1'b1;
`else
        if (starve >= LIM) g1 = 1'b1; else g0 = 1'b1;
`endif
      end
    end
    check_eq("req_ready", 64'(req_ready), 64'({g1, g0}));
    check_eq("arb_owner", 64'(arb_owner), 64'(g1));
    check_eq("mem_wr", 64'(mem_wr), 64'(exp_wr));
    check_eq("mem_rd", 64'(mem_rd), 64'(exp_rd));
    check_eq("mem_addr", 64'(mem_addr), 64'(exp_addr));
    check_eq("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
    exp_rv   = 2'b00;
    exp_data = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rv[rq[0].port] = 1'b1;
      exp_data           = rq[0].data;
      void'(rq.pop_front());
    end
    check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv != 2'b00) check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_data));
    last_grant = {g1, g0};

    if (r) begin
      starve    = 0;
      pref_aux  = 1'b0;
      rq.delete();
      exp_wr    = 1'b0;
      exp_rd    = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
    end else begin
      exp_wr = 1'b0;
      exp_rd = 1'b0;
      if (g0 || g1) begin
        p         = g1;
        exp_wr    = we[p];
        exp_rd    = !we[p];
        exp_addr  = p ? a1 : a0;
        exp_wdata = p ? d1 : d0;
        if (we[p]) begin
          ref_mem[exp_addr] = exp_wdata;
        end else begin
          e.due  = cyc + 2;
          e.port = p;
          e.data = ref_mem[exp_addr];
          rq.push_back(e);
        end
        pref_aux = !p;
      end
      if (!v[1] || g1) starve = 0;
      else if (starve < LIM) starve++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  logic [1:0]    cur_v, cur_we;
  logic [AW-1:0] cur_a [2];
  logic [DW-1:0] cur_d [2];

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    @(posedge clk);
    #1 mem_init = 1'b0;
    @(posedge clk);

    // Write then read back the same word from port 0.
    step(1'b0, 2'b01, 2'b01, 9'd4, '0, 32'hDEADBEEF, '0);
    step(1'b0, 2'b01, 2'b00, 9'd4, '0, '0, '0);
    idle(3);

    // Alternating reads: port 1 then port 0.
    step(1'b0, 2'b10, 2'b00, '0, 9'd10, '0, '0);
    step(1'b0, 2'b01, 2'b00, 9'd11, '0, '0, '0);
    idle(3);

    // Both ports reading continuously.
    for (int i = 0; i < 20; i++) step(1'b0, 2'b11, 2'b00, AW'(i), AW'(100 + i), '0, '0);
    idle(5);

    // Port 1 drops valid exactly when it would have been promoted.
    for (int i = 0; i < LIM; i++) step(1'b0, 2'b11, 2'b00, AW'(i), 9'h1FF, '0, '0);
    step(1'b0, 2'b01, 2'b00, 9'd3, '0, '0, '0);
    step(1'b0, 2'b11, 2'b00, 9'd5, 9'h1FF, '0, '0);
    idle(3);

    // Reset while a read is in flight, then a tie right after reset.
    step(1'b0, 2'b01, 2'b00, 9'd7, '0, '0, '0);
    step(1'b1, 2'b11, 2'b00, 9'd7, 9'd8, '0, '0);
    step(1'b1, 2'b11, 2'b00, 9'd7, 9'd8, '0, '0);
    step(1'b0, 2'b11, 2'b00, 9'd7, 9'd8, '0, '0);
    idle(3);

    // Randomized traffic; a stalled request is usually held with stable fields.
    cur_v  = '0;
    cur_we = '0;
    for (int i = 0; i < 2; i++) begin
      cur_a[i] = '0;
      cur_d[i] = '0;
    end
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(cur_v[i] && !last_grant[i] && $urandom_range(7, 0) != 0)) begin
          cur_v[i]  = ($urandom_range(9, 0) < ((i == 0) ? 7 : 6));
          cur_we[i] = ($urandom_range(2, 0) == 0);
          cur_a[i]  = ($urandom_range(15, 0) == 0) ? 9'h1FF : AW'($urandom_range(15, 0));
          cur_d[i]  = $urandom;
        end
      end
      step(($urandom_range(299, 0) == 0), cur_v, cur_we, cur_a[0], cur_a[1], cur_d[0], cur_d[1]);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
